// File: rtl/pq_arb_pkg.sv
// Shared types for the priority-queue arbiter: the {key,val} entry and the dequeue FSM states.
package pq_pkg;

    localparam int KEY_WIDTH = 8;
    localparam int VAL_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } kv_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } deq_state_e;

endpackage

// File: rtl/pq_arb_if.sv
// Bundle of requester, consumer and priority-queue signals around pq_arb.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface pq_arb_if #(
    parameter int NREQ = 4
);
    import pq_pkg::*;

    logic [NREQ-1:0] enq_req;
    kv_t  [NREQ-1:0] enq_kv;
    logic [NREQ-1:0] enq_gnt;

    logic            deq_req;
    logic            deq_valid;
    kv_t             deq_kv;
    logic            deq_ready;

    logic            pq_enq;
    logic            pq_deq;
    kv_t             pq_kvi;
    logic            pq_full;
    logic            pq_empty;
    logic            pq_busy;
    kv_t             pq_kvo;

    modport slave (
        input  enq_req, enq_kv, deq_req, deq_ready,
        input  pq_full, pq_empty, pq_busy, pq_kvo,
        output enq_gnt, deq_valid, deq_kv, pq_enq, pq_deq, pq_kvi
    );

    modport master (
        output enq_req, enq_kv, deq_req, deq_ready,
        output pq_full, pq_empty, pq_busy, pq_kvo,
        input  enq_gnt, deq_valid, deq_kv, pq_enq, pq_deq, pq_kvi
    );

endinterface

// File: rtl/pq_arb_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NREQ.
module rr_arb #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW-1:0] j;

    // Scan from the farthest candidate back to ptr so the nearest one is written last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = j;
            end
        end
    end

endmodule

// File: rtl/pq_arb.sv
// pq_arb: round-robin enqueue arbitration plus a single-outstanding dequeue FSM in front of a priority queue.
// Define PQ_ARB_COMBINE_EN to allow enqueue and dequeue to be issued together in one cycle.
module pq_arb
    import pq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DEQ_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    pq_arb_if.slave bus
);

    localparam int         IW       = $clog2(NREQ);
    localparam logic [1:0] LAT_LAST = 2'(DEQ_LAT - 1);

    deq_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            last_deq_q, last_deq_d;
    kv_t             deq_kv_q, deq_kv_d;

    logic [NREQ-1:0] rr_gnt;
    logic [IW-1:0]   rr_idx;
    logic            enq_pend;
    logic            enq_elig;
    logic            deq_elig;
    logic            issue_enq;
    logic            issue_deq;

    rr_arb #(.NREQ(NREQ)) u_rr (
        .req     (bus.enq_req),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Strobes are combinational, so reset must also mask them directly.
    always_comb begin
        enq_pend  = |bus.enq_req;
        enq_elig  = enq_pend & ~bus.pq_full;
        deq_elig  = bus.deq_req & ~bus.pq_empty & (state_q == IDLE);
        issue_enq = 1'b0;
        issue_deq = 1'b0;
        if (!rst && !bus.pq_busy) begin
`ifdef PQ_ARB_COMBINE_EN
            if (deq_elig && enq_pend) begin
                issue_enq = 1'b1;
                issue_deq = 1'b1;
            end else begin
                issue_enq = enq_elig;
                issue_deq = deq_elig;
            end
`else
            if (enq_elig && deq_elig) begin
                issue_enq = last_deq_q;
                issue_deq = ~last_deq_q;
            end else begin
                issue_enq = enq_elig;
                issue_deq = deq_elig;
            end
`endif
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        last_deq_d = last_deq_q;
        if (issue_enq) begin
            ptr_d = (rr_idx == IW'(NREQ - 1)) ? '0 : rr_idx + 1'b1;
        end
        if (issue_enq ^ issue_deq) begin
            last_deq_d = issue_deq;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        deq_kv_d = deq_kv_q;
        case (state_q)
            IDLE: begin
                if (issue_deq) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d  = HOLD;
                    deq_kv_d = bus.pq_kvo;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            HOLD: begin
                if (bus.deq_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            last_deq_q <= 1'b0;
            deq_kv_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            last_deq_q <= last_deq_d;
            deq_kv_q   <= deq_kv_d;
        end
    end

    assign bus.enq_gnt   = issue_enq ? rr_gnt : '0;
    assign bus.pq_enq    = issue_enq;
    assign bus.pq_deq    = issue_deq;
    assign bus.pq_kvi    = bus.enq_kv[rr_idx];
    assign bus.deq_valid = (state_q == HOLD);
    assign bus.deq_kv    = deq_kv_q;

endmodule

// File: doc/pq_arb.md
PQ_ARB -- requirements
Module: pq_arb

Interface
REQ-001 The module SHALL have parameter NREQ, default 4, meaning the number of enqueue requesters (2..8).
REQ-002 The module SHALL have parameter DEQ_LAT, default 1, meaning the cycles from pq_deq asserted to pq_kvo valid (1..4).
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The module SHALL have port enq_req, input, NREQ, meaning per-requester enqueue request (level, held until granted).
REQ-006 The module SHALL have port enq_kv, input, NREQ x kv_t, meaning per-requester {key,val}, stable while enq_req is high.
REQ-007 The module SHALL have port enq_gnt, output, NREQ, meaning one-hot accept, high for one cycle.
REQ-008 The module SHALL have port deq_req, input, 1, meaning the consumer wants the minimum entry.
REQ-009 The module SHALL have port deq_valid, output, 1, meaning deq_kv holds a result.
REQ-010 The module SHALL have port deq_kv, output, kv_t, meaning the dequeued {key,val}.
REQ-011 The module SHALL have port deq_ready, input, 1, meaning the consumer accepts deq_kv.
REQ-012 The module SHALL have ports pq_enq, output, 1, and pq_deq, output, 1, meaning the PQ operation strobes.
REQ-013 The module SHALL have port pq_kvi, output, kv_t, meaning the PQ insert data.
REQ-014 The module SHALL have ports pq_full, pq_empty and pq_busy, input, 1 each, meaning the PQ status; pq_busy=1 means no operation is accepted this cycle.
REQ-015 The module SHALL have port pq_kvo, input, kv_t, meaning the PQ dequeue data.

Function
REQ-016 The module SHALL issue no PQ operation in any cycle where pq_busy=1.
REQ-017 An enqueue SHALL be eligible when |enq_req is set and pq_full=0.
REQ-018 A dequeue SHALL be eligible when deq_req=1, pq_empty=0 and the deq FSM is IDLE.
REQ-019 The enqueue winner SHALL be chosen round-robin from pointer ptr; after granting requester i, ptr SHALL become (i+1) mod NREQ; ptr SHALL be unchanged with no grant.
REQ-020 pq_enq, enq_gnt[i] and pq_kvi=enq_kv[i] SHALL be asserted combinationally in the same cycle.
REQ-021 If only one of enqueue or dequeue is eligible, it SHALL be issued alone.
REQ-022 If both are eligible and combining is disabled, the module SHALL issue the one opposite to the last issued single operation (toggle bit last_deq) and update last_deq.
REQ-023 The deq FSM SHALL have three states: IDLE->WAIT when pq_deq is issued; WAIT SHALL count DEQ_LAT cycles and then capture pq_kvo into deq_kv and go to HOLD; HOLD SHALL hold deq_valid=1, and HOLD->IDLE SHALL occur on deq_ready=1.
REQ-024 At most one dequeue SHALL be outstanding, and deq_kv SHALL stay stable while in HOLD.
REQ-025 deq_req asserted during WAIT or HOLD SHALL be ignored until IDLE.
REQ-026 NREQ requesters all held high SHALL each receive a grant within NREQ enqueue issues.

Reset
REQ-027 On rst, the module SHALL immediately force ptr=0, last_deq=0, FSM=IDLE, deq_valid=0, deq_kv=0, enq_gnt=0, pq_enq=0 and pq_deq=0.
REQ-028 Reset asserted in WAIT or HOLD SHALL discard the in-flight result; the first operation SHALL be allowed in the first cycle after rst deasserts.

Configuration
REQ-029 Macro PQ_ARB_COMBINE_EN defined: when both operations are eligible, or when an enqueue is pending with pq_full=1 and a dequeue is eligible, the module SHALL issue pq_enq=pq_deq=1 in one cycle (count unchanged), grant the enqueue winner, start the deq FSM, and leave last_deq untouched.
REQ-030 Macro PQ_ARB_COMBINE_EN undefined: the module SHALL never assert pq_enq and pq_deq together, and the REQ-022 alternation SHALL apply.

Structure
REQ-031 pq_pkg SHALL hold KEY_WIDTH, VAL_WIDTH, typedef kv_t = {key,val}, and the deq FSM state enum (IDLE, WAIT, HOLD).
REQ-032 Round-robin selection SHALL be sub-module rr_arb (NREQ, req, ptr -> one-hot gnt, gnt_idx); all other logic SHALL reside in pq_arb.

Verification
REQ-033 With enq_req=4'b1111 held, kv=(8,14),(11,11),(9,9),(10,10), and pq idle, grants SHALL be 0,1,2,3 on consecutive cycles, then draining SHALL return keys 8,9,10,11.
REQ-034 With pq_empty=1 and deq_req=1, no pq_deq SHALL be issued and deq_valid SHALL stay 0.
REQ-035 With one entry (5,7) queued, deq_req=1 and deq_ready=0 for 5 cycles, deq_valid SHALL rise DEQ_LAT+1 cycles after pq_deq, deq_kv=(5,7) SHALL be held, and it SHALL clear one cycle after deq_ready=1.
REQ-036 With pq_full=1, enq_req[2]=1 and deq_req=1: COMBINE_EN SHALL give pq_enq=pq_deq=1 and enq_gnt=4'b0100 in the same cycle; without it, only pq_deq SHALL be issued, and the enqueue SHALL be issued once pq_full drops.
REQ-037 With pq_busy=1 for 3 cycles under pending requests, there SHALL be no strobes or grants and ptr SHALL be unchanged; rst asserted during WAIT SHALL leave deq_valid=0 afterwards.
